instr_encoder: RTL and testbench

- Inverse of the core's immediate decode: packs opcode, register fields, funct fields and a 32-bit immediate into a 32-bit RV32I instruction word.
- Two-stage valid/ready pipeline:
  - Stage 1 registers the fields and checks immediate range.
  - Stage 2 scatters the immediate bits into the format layout.
- Feeds the instruction-memory loader / self-test path. Each output word is tagged with a sequential byte address.

---
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder.sv | 162 ++++++++++++++++
 tb/tb_instr_encoder.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Field-set in / encoded-word out handshake bundle for instr_encoder.
// master = field producer (loader / self-test), slave = the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 14
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              in_clr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output in_clr, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  in_clr, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field packer: opcode/regs/funct/immediate in, 32-bit instruction word + byte address out.
// Latency 2 cycles (field register, then immediate scatter); 1 word/cycle; in_ready falls only when both stages hold a word and out_ready is low.
// INSTR_ENCODER_IMM_CHECK_EN enables the immediate range check driving out_err; otherwise out_err is tied 0.
module instr_encoder #(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic             clk,
    input  logic             rstn,
    instr_encoder_if.slave   bus
);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    typedef struct packed {
        logic [6:0]  funct7;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [31:0] imm;
        fmt_e        fmt;
    } fields_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    fmt_e              fmt_d;
    fields_t           s1_d;
    fields_t           s1_q;
    logic              s1_valid;
    logic              s1_adv;
    logic              s2_adv;
    logic [31:0]       instr_d;
    logic [31:0]       instr_q;
    logic              out_valid_q;
    logic [ADDR_W-1:0] addr_q;

    // Both advance terms are pure functions of local state plus out_ready.
    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    always_comb begin
        case (bus.in_op)
            7'b0010011, 7'b1100111, 7'b0000011: fmt_d = FMT_I;
            7'b0100011:                         fmt_d = FMT_S;
            7'b1100011:                         fmt_d = FMT_B;
            7'b0110111, 7'b0010111:             fmt_d = FMT_U;
            7'b1101111:                         fmt_d = FMT_J;
            default:                            fmt_d = FMT_R;
        endcase
    end

    assign s1_d = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   bus.in_rd, bus.in_op, bus.in_imm, fmt_d};

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    logic err_d;
    logic s1_err;
    logic out_err_q;
    logic sext12_ok;
    logic sext13_ok;
    logic sext21_ok;

    // An immediate fits n signed bits when every bit from n-1 upward matches.
    assign sext12_ok = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
    assign sext13_ok = (&bus.in_imm[31:12]) || !(|bus.in_imm[31:12]);
    assign sext21_ok = (&bus.in_imm[31:20]) || !(|bus.in_imm[31:20]);

    always_comb begin
        err_d = 1'b0;
        case (fmt_d)
            FMT_I, FMT_S: err_d = !sext12_ok;
            FMT_B:        err_d = !sext13_ok || bus.in_imm[0];
            FMT_J:        err_d = !sext21_ok || bus.in_imm[0];
            FMT_U:        err_d = |bus.in_imm[11:0];
            default:      err_d = 1'b0;
        endcase
    end

    assign bus.out_err = out_err_q;
`else
    assign bus.out_err = 1'b0;
`endif

    always_comb begin
        instr_d = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.op};
        case (s1_q.fmt)
            FMT_I: instr_d = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.op};
            FMT_S: instr_d = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                              s1_q.imm[4:0], s1_q.op};
            FMT_B: instr_d = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                              s1_q.funct3, s1_q.imm[4:1], s1_q.imm[11], s1_q.op};
            FMT_U: instr_d = {s1_q.imm[31:12], s1_q.rd, s1_q.op};
            FMT_J: instr_d = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                              s1_q.imm[19:12], s1_q.rd, s1_q.op};
            default: instr_d = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                s1_q.rd, s1_q.op};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
            s1_err   <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= s1_d;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                s1_err <= err_d;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
            out_err_q   <= 1'b0;
`endif
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                instr_q <= instr_d;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                out_err_q <= s1_err;
`endif
            end
        end
    end

    // Clear wins over the increment; the word leaving this cycle keeps the old address.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q <= BASE;
        end else if (bus.in_clr) begin
            addr_q <= BASE;
        end else if (out_valid_q && bus.out_ready) begin
            addr_q <= addr_q + STEP;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued on acceptance, compared on output transfer.
module tb_instr_encoder;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] ei;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_acc  = 0;
    exp_t sb[$];
    logic [13:0] exp_addr;

    instr_encoder_if #(.ADDR_W(14)) bus ();
    instr_encoder_if #(.ADDR_W(4))  busw ();

    instr_encoder #(.ADDR_W(14), .BASE_ADDR(0)) dut   (.clk(clk), .rstn(rstn), .bus(bus));
    instr_encoder #(.ADDR_W(4),  .BASE_ADDR(0)) dut_w (.clk(clk), .rstn(rstn), .bus(busw));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.in_valid = 0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0; bus.in_clr = 0; bus.out_ready = 0;
        busw.in_valid = 0; busw.in_op = '0; busw.in_rd = '0; busw.in_rs1 = '0; busw.in_rs2 = '0;
        busw.in_funct3 = '0; busw.in_funct7 = '0; busw.in_imm = '0; busw.in_clr = 0; busw.out_ready = 0;
    endtask

    // Offer one field set; push its expectation at the accepting edge.
    task automatic send(input vec_t v, output int pc);
        bit done = 0;
        pc = -1;
        bus.in_valid = 1; bus.in_op = v.op; bus.in_rd = v.rd; bus.in_rs1 = v.rs1;
        bus.in_rs2 = v.rs2; bus.in_funct3 = v.f3; bus.in_funct7 = v.f7; bus.in_imm = v.imm;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                pc = cyc; done = 1;
                sb.push_back('{v.ei, v.ee});
                n_acc++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_accept: op=%b never accepted, required acceptance within 40 cycles", v.op);
        end
    endtask

    // Wait for one output transfer and return what was on the bus.
    task automatic wait_out(output logic [31:0] i, output logic [13:0] a, output logic e,
                            output int oc, output bit to);
        to = 1; i = '0; a = '0; e = 0; oc = -1;
        for (int k = 0; k < 40 && to; k++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                i = bus.out_instr; a = bus.out_addr; e = bus.out_err; oc = cyc; to = 0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        idle();
        rstn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", bus.out_valid); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b need 0", bus.out_err); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h need 00000000", bus.out_instr); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready); end
        @(posedge clk); #1;
        rstn = 1;
        exp_addr = '0;
    endtask

    task automatic test_addi();
        logic [31:0] oi; logic [13:0] oa; logic oe; int oc, pc; bit to;
        exp_t x;
        bus.out_ready = 1;
        send('{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0}, pc);
        wait_out(oi, oa, oe, oc, to);
        checks++;
        if (to || sb.size() == 0) begin
            errors++; $display("FAIL addi_out: timeout=%0d queued=%0d, required one word", to, sb.size());
        end else begin
            x = sb.pop_front();
            checks++; if (oi !== x.instr) begin errors++; $display("FAIL addi_instr: got %h need %h", oi, x.instr); end
            checks++; if (oa !== exp_addr) begin errors++; $display("FAIL addi_addr: got %h need %h", oa, exp_addr); end
            checks++; if (oe !== x.err) begin errors++; $display("FAIL addi_err: got %b need %b", oe, x.err); end
            checks++; if (oc - pc != 2) begin errors++; $display("FAIL addi_latency: got %0d cycles need 2", oc - pc); end
            exp_addr += 14'd4;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[4];
        int   pcs[4];
        int   last_oc;
        v[0] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423, 1'b0};
        v[1] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1'b0};
        v[2] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0};
        v[3] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFFFFFF, 32'h402081B3, 1'b0};
        bus.out_ready = 1;
        bus.in_clr = 1;
        @(posedge clk); #1;
        bus.in_clr = 0;
        exp_addr = '0;
        last_oc = -1;
        fork
            for (int k = 0; k < 4; k++) send(v[k], pcs[k]);
            for (int k = 0; k < 4; k++) begin
                logic [31:0] oi; logic [13:0] oa; logic oe; int oc; bit to; exp_t x;
                wait_out(oi, oa, oe, oc, to);
                checks++;
                if (to || sb.size() == 0) begin
                    errors++; $display("FAIL b2b_out%0d: timeout=%0d queued=%0d, required a word", k, to, sb.size());
                end else begin
                    x = sb.pop_front();
                    checks++; if (oi !== x.instr) begin errors++; $display("FAIL b2b_instr%0d: got %h need %h", k, oi, x.instr); end
                    checks++; if (oa !== exp_addr) begin errors++; $display("FAIL b2b_addr%0d: got %h need %h", k, oa, exp_addr); end
                    checks++; if (oe !== x.err) begin errors++; $display("FAIL b2b_err%0d: got %b need %b", k, oe, x.err); end
                    if (k > 0) begin
                        checks++; if (oc - last_oc != 1) begin errors++; $display("FAIL b2b_rate%0d: gap %0d cycles need 1", k, oc - last_oc); end
                    end
                    last_oc = oc;
                    exp_addr += 14'd4;
                end
            end
        join
        for (int k = 1; k < 4; k++) begin
            checks++; if (pcs[k] - pcs[k-1] != 1) begin errors++; $display("FAIL b2b_accept%0d: gap %0d cycles need 1", k, pcs[k] - pcs[k-1]); end
        end
    endtask

    task automatic test_backpressure();
        vec_t v[3];
        int   base;
        v[0] = '{7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100113, 1'b0};
        v[1] = '{7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200193, 1'b0};
        v[2] = '{7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00300213, 1'b0};
        bus.out_ready = 0;
        base = n_acc;
        fork
            for (int k = 0; k < 3; k++) begin int pc; send(v[k], pc); end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                checks++; if (n_acc - base != 2) begin errors++; $display("FAIL bp_accepts: got %0d need 2", n_acc - base); end
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b need 0", bus.in_ready); end
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_instr !== v[0].ei || bus.out_addr !== exp_addr) begin
                        errors++;
                        $display("FAIL bp_hold%0d: got v=%b %h @%h need v=1 %h @%h", k, bus.out_valid,
                                 bus.out_instr, bus.out_addr, v[0].ei, exp_addr);
                    end
                    @(negedge clk);
                end
                @(posedge clk); #1;
                bus.out_ready = 1;
                for (int k = 0; k < 3; k++) begin
                    logic [31:0] oi; logic [13:0] oa; logic oe; int oc; bit to; exp_t x;
                    wait_out(oi, oa, oe, oc, to);
                    checks++;
                    if (to || sb.size() == 0) begin
                        errors++; $display("FAIL bp_out%0d: timeout=%0d queued=%0d, required a word", k, to, sb.size());
                    end else begin
                        x = sb.pop_front();
                        checks++; if (oi !== x.instr) begin errors++; $display("FAIL bp_instr%0d: got %h need %h", k, oi, x.instr); end
                        checks++; if (oa !== exp_addr) begin errors++; $display("FAIL bp_addr%0d: got %h need %h", k, oa, exp_addr); end
                        exp_addr += 14'd4;
                    end
                end
            end
        join
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: out_valid=%b need 0", bus.out_valid); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_queue: %0d left need 0", sb.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_range();
        vec_t v[9];
        v[0] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,          32'h00000163, CHK};
        v[1] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800,   32'h80000093, CHK};
        v[2] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800,   32'h80000093, 1'b0};
        v[3] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001,   32'h000012B7, CHK};
        v[4] = '{7'h03, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC,   32'hFFC12303, 1'b0};
        v[5] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8,   32'hFE208CE3, 1'b0};
        v[6] = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000,   32'h8000006F, CHK};
        v[7] = '{7'h23, 5'd0, 5'd0, 5'd0, 3'd2, 7'd0, 32'h00001000,   32'h00002023, CHK};
        v[8] = '{7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0,          32'h00008067, 1'b0};
        bus.out_ready = 1;
        for (int k = 0; k < 9; k++) begin
            logic [31:0] oi; logic [13:0] oa; logic oe; int oc, pc; bit to; exp_t x;
            send(v[k], pc);
            wait_out(oi, oa, oe, oc, to);
            checks++;
            if (to || sb.size() == 0) begin
                errors++; $display("FAIL rng_out%0d: timeout=%0d queued=%0d, required a word", k, to, sb.size());
            end else begin
                x = sb.pop_front();
                checks++; if (oi !== x.instr) begin errors++; $display("FAIL rng_instr%0d: got %h need %h", k, oi, x.instr); end
                checks++; if (oe !== x.err) begin errors++; $display("FAIL rng_err%0d: got %b need %b", k, oe, x.err); end
                exp_addr += 14'd4;
            end
        end
    endtask

    task automatic test_clr();
        logic [31:0] oi; logic [13:0] oa; logic oe; int oc, pc; bit to; exp_t x;
        vec_t w;
        bus.out_ready = 1;
        bus.in_clr = 1;
        @(posedge clk); #1;
        bus.in_clr = 0;
        exp_addr = '0;
        fork
            for (int k = 1; k <= 4; k++) begin
                int p;
                send('{7'h33, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00208033 | (32'(k) << 7), 1'b0}, p);
            end
            for (int k = 0; k < 4; k++) begin
                logic [31:0] ci; logic [13:0] ca; logic ce; int co; bit ct; exp_t cx;
                wait_out(ci, ca, ce, co, ct);
                checks++;
                if (ct || sb.size() == 0) begin
                    errors++; $display("FAIL clr_pre%0d: timeout=%0d queued=%0d, required a word", k, ct, sb.size());
                end else begin
                    cx = sb.pop_front();
                    checks++; if (ca !== exp_addr || ci !== cx.instr) begin
                        errors++; $display("FAIL clr_pre%0d: got %h @%h need %h @%h", k, ci, ca, cx.instr, exp_addr);
                    end
                    exp_addr += 14'd4;
                end
            end
        join
        bus.out_ready = 0;
        w = '{7'h33, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002082B3, 1'b0};
        send(w, pc);
        w = '{7'h33, 5'd6, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00208333, 1'b0};
        send(w, pc);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 14'h10) begin
            errors++; $display("FAIL clr_stage: got v=%b @%h need v=1 @0010", bus.out_valid, bus.out_addr);
        end
        @(posedge clk); #1;
        bus.out_ready = 1;
        bus.in_clr = 1;
        wait_out(oi, oa, oe, oc, to);
        bus.in_clr = 0;
        checks++;
        if (to || sb.size() == 0) begin
            errors++; $display("FAIL clr_word: timeout=%0d, required a word", to);
        end else begin
            x = sb.pop_front();
            checks++; if (oa !== 14'h10 || oi !== x.instr) begin errors++; $display("FAIL clr_same: got %h @%h need %h @0010", oi, oa, x.instr); end
        end
        exp_addr = '0;
        wait_out(oi, oa, oe, oc, to);
        checks++;
        if (to || sb.size() == 0) begin
            errors++; $display("FAIL clr_next_word: timeout=%0d, required a word", to);
        end else begin
            x = sb.pop_front();
            checks++; if (oa !== exp_addr || oi !== x.instr) begin errors++; $display("FAIL clr_next: got %h @%h need %h @%h", oi, oa, x.instr, exp_addr); end
            exp_addr += 14'd4;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] wexp;
        int cnt;
        wexp = 4'h0;
        cnt = 0;
        busw.out_ready = 1;
        busw.in_op = 7'h33; busw.in_rd = 5'd3; busw.in_rs1 = 5'd1; busw.in_rs2 = 5'd2;
        busw.in_funct3 = 3'd0; busw.in_funct7 = 7'd0; busw.in_imm = 32'd0;
        fork
            begin
                busw.in_valid = 1;
                repeat (5) @(posedge clk);
                #1 busw.in_valid = 0;
            end
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (busw.out_valid && busw.out_ready) begin
                    checks++;
                    if (busw.out_addr !== wexp || busw.out_instr !== 32'h002081B3) begin
                        errors++; $display("FAIL wrap_word%0d: got %h @%h need 002081b3 @%h", cnt, busw.out_instr, busw.out_addr, wexp);
                    end
                    wexp += 4'd4;
                    cnt++;
                end
            end
        join
        checks++; if (cnt != 5) begin errors++; $display("FAIL wrap_count: got %0d words need 5", cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_inflight();
        logic [31:0] oi; logic [13:0] oa; logic oe; int oc, pc; bit to; exp_t x;
        bus.out_ready = 0;
        send('{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h80000093, CHK}, pc);
        send('{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3, 1'b0}, pc);
        sb.delete();
        rstn = 0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst2_valid: got %b need 0", bus.out_valid); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL rst2_err: got %b need 0", bus.out_err); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst2_in_ready: got %b need 1", bus.in_ready); end
        @(posedge clk); #1;
        rstn = 1;
        exp_addr = '0;
        bus.out_ready = 1;
        send('{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1'b0}, pc);
        wait_out(oi, oa, oe, oc, to);
        checks++;
        if (to || sb.size() == 0) begin
            errors++; $display("FAIL rst2_word: timeout=%0d, required a word", to);
        end else begin
            x = sb.pop_front();
            checks++; if (oa !== exp_addr || oi !== x.instr) begin errors++; $display("FAIL rst2_next: got %h @%h need %h @%h", oi, oa, x.instr, exp_addr); end
        end
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst2_flushed: out_valid=%b need 0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_range();
        test_clr();
        test_wrap();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
